// File: rtl/alu_pkg.sv
// Shared retire-stage definitions: opcode encoding, status bit positions,
// word geometry and the buffered-entry layout.
package alu_pkg;

  localparam int WORD_W  = 20;
  localparam int HALF_W  = 10;
  localparam int RADDR_W = 3;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_WRF  = 4'd1,
    OP_WRN  = 4'd2,
    OP_LSR  = 4'd3,
    OP_XSR  = 4'd4,
    OP_JMP  = 4'd5,
    OP_JZ   = 4'd6,
    OP_JS   = 4'd7,
    OP_JZS  = 4'd8,
    OP_TRAP = 4'd9
  } retire_op_t;

  localparam int ST_Z = 0;
  localparam int ST_S = 1;
  localparam int ST_C = 2;
  localparam int ST_T = 3;

  typedef struct packed {
    logic [3:0]         op;
    logic               mode;
    logic [WORD_W-1:0]  result;
    logic               carry;
    logic [RADDR_W-1:0] dest;
  } retire_entry_t;

  // Half-word mode zero-extends the low half of the ALU result.
  function automatic logic [WORD_W-1:0] mask_data(input logic mode,
                                                  input logic [WORD_W-1:0] result);
    return mode ? result : {{(WORD_W-HALF_W){1'b0}}, result[HALF_W-1:0]};
  endfunction

endpackage

// File: rtl/retire_skid_fifo.sv
// Two-entry skid FIFO holding ALU results until they retire; flush empties it
// and wins over a same-cycle push.
module retire_skid_fifo
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  retire_entry_t din,
  output retire_entry_t dout,
  output logic [1:0]    count
);

  retire_entry_t mem [2];
  logic          rd_ptr;
  logic          wr_ptr;

  assign dout = mem[rd_ptr];

  // NOTE: storage carries no reset; count and the pointers alone define which
  // slots are valid, so the data array stays a plain register bank.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_retire_stage.sv
// ALU writeback/retire stage: buffers results, retires one per cycle in order,
// updates {T,C,S,Z}, resolves conditional jumps and handles TRAP.
module alu_retire_stage
  import alu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_op,
  input  logic               in_mode,
  input  logic [WORD_W-1:0]  in_result,
  input  logic               in_carry,
  input  logic [RADDR_W-1:0] in_dest,
  input  logic               wb_ready,
  input  logic               trap_clr,
  output logic               wb_we,
  output logic [RADDR_W-1:0] wb_addr,
  output logic [WORD_W-1:0]  wb_data,
  output logic               br_taken,
  output logic [WORD_W-1:0]  br_target,
  output logic [3:0]         status,
  output logic               trapped
);

  localparam logic [0:0] S_RUN     = 1'b0;
  localparam logic [0:0] S_TRAPPED = 1'b1;

  logic [0:0]        state;
  logic [1:0]        count;
  logic              push;
  logic              pop;
  logic              flush;
  retire_entry_t     din;
  retire_entry_t     hd;
  retire_op_t        hd_op;
  logic [WORD_W-1:0] hd_data;
  logic              hd_sign;
  logic              hd_zero;
  logic              br_cond;

  assign in_ready = (count < 2'd2) && (state == S_RUN);
  assign push     = in_valid && in_ready;
  assign pop      = (count != 2'd0) && wb_ready && (state == S_RUN);
  // Entries queued behind a retiring TRAP (including a same-cycle push) die here.
  assign flush    = pop && (hd_op == OP_TRAP);
  assign trapped  = (state == S_TRAPPED);

  assign din = '{op: in_op, mode: in_mode, result: in_result, carry: in_carry, dest: in_dest};

  retire_skid_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (din),
    .dout  (hd),
    .count (count)
  );

  // Reserved encodings fall through to the default arm and retire as NOP.
  assign hd_op   = retire_op_t'(hd.op);
  assign hd_data = mask_data(hd.mode, hd.result);
  assign hd_sign = hd.mode ? hd.result[WORD_W-1] : hd.result[HALF_W-1];
  assign hd_zero = (hd_data == '0);

  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    br_cond = 1'b0;
    case (hd_op)
      OP_JMP:  br_cond = 1'b1;
      OP_JZ:   br_cond = status[ST_Z];
      OP_JS:   br_cond = status[ST_S];
      OP_JZS:  br_cond = status[ST_Z] | status[ST_S];
      default: br_cond = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_RUN;
      status    <= 4'b0000;
      wb_we     <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
      br_taken  <= 1'b0;
      br_target <= '0;
    end else begin
      wb_we    <= 1'b0;
      br_taken <= 1'b0;
      if (state == S_TRAPPED) begin
        if (trap_clr) begin
          state        <= S_RUN;
          status[ST_T] <= 1'b0;
        end
      end else if (pop) begin
        case (hd_op)
          OP_WRF: begin
            wb_we                <= 1'b1;
            wb_addr              <= hd.dest;
            wb_data              <= hd_data;
            status[ST_C:ST_Z]    <= {hd.carry, hd_sign, hd_zero};
          end
          OP_WRN: begin
            wb_we   <= 1'b1;
            wb_addr <= hd.dest;
            wb_data <= hd_data;
          end
          OP_LSR: status[ST_C:ST_Z] <= hd.result[2:0];
          OP_XSR: status[ST_C:ST_Z] <= status[ST_C:ST_Z] ^ hd.result[2:0];
          OP_JMP, OP_JZ, OP_JS, OP_JZS: begin
            if (br_cond) begin
              br_taken  <= 1'b1;
              br_target <= hd_data;
            end
          end
          OP_TRAP: begin
            status[ST_T] <= 1'b1;
            state        <= S_TRAPPED;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_retire_stage.sv
// Directed bench for alu_retire_stage with a scoreboard of expected retires
// (register writes and taken redirects) built from a behavioural model.
module tb_alu_retire_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic        in_mode;
  logic [19:0] in_result;
  logic        in_carry;
  logic [2:0]  in_dest;
  logic        wb_ready;
  logic        trap_clr;
  logic        wb_we;
  logic [2:0]  wb_addr;
  logic [19:0] wb_data;
  logic        br_taken;
  logic [19:0] br_target;
  logic [3:0]  status;
  logic        trapped;

  alu_retire_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_mode   (in_mode),
    .in_result (in_result),
    .in_carry  (in_carry),
    .in_dest   (in_dest),
    .wb_ready  (wb_ready),
    .trap_clr  (trap_clr),
    .wb_we     (wb_we),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .br_taken  (br_taken),
    .br_target (br_target),
    .status    (status),
    .trapped   (trapped)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] NOP = 4'd0, WRF = 4'd1, WRN = 4'd2, LSR = 4'd3, XSR = 4'd4,
                         JMP = 4'd5, JZ = 4'd6, JS = 4'd7, JZS = 4'd8, TRAP = 4'd9;

  typedef struct {
    bit          we;
    logic [2:0]  addr;
    logic [19:0] data;
    bit          br;
    logic [19:0] tgt;
    logic [3:0]  st;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] m_st = 4'b0000;
  bit         m_trapped = 1'b0;
  int         checks = 0;
  int         failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // In-order behavioural model of one accepted entry.
  function automatic void model(input logic [3:0] op, input logic mode,
                                input logic [19:0] res, input logic c, input logic [2:0] d);
    logic [19:0] data;
    logic        sign;
    bit          taken;
    exp_t        e;
    if (m_trapped) return;
    data  = mode ? res : {10'b0, res[9:0]};
    sign  = mode ? res[19] : res[9];
    taken = 1'b0;
    e     = '{we: 1'b0, addr: d, data: data, br: 1'b0, tgt: data, st: 4'b0};
    case (op)
      WRF: begin m_st[2:0] = {c, sign, (data == 20'd0)}; e.we = 1'b1; end
      WRN: e.we = 1'b1;
      LSR: m_st[2:0] = res[2:0];
      XSR: m_st[2:0] = m_st[2:0] ^ res[2:0];
      JMP: taken = 1'b1;
      JZ:  taken = m_st[0];
      JS:  taken = m_st[1];
      JZS: taken = m_st[0] | m_st[1];
      TRAP: begin m_st[3] = 1'b1; m_trapped = 1'b1; end
      default: ;
    endcase
    e.br = taken;
    e.st = m_st;
    if (e.we || e.br) exp_q.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (!rst && (wb_we || br_taken)) begin
      if (exp_q.size() == 0) begin
        check("spurious_retire", 32'({wb_we, br_taken}), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_we", 32'(wb_we), 32'(e.we));
        check("sb_br", 32'(br_taken), 32'(e.br));
        if (e.we) begin
          check("sb_addr", 32'(wb_addr), 32'(e.addr));
          check("sb_data", 32'(wb_data), 32'(e.data));
        end
        if (e.br) check("sb_target", 32'(br_target), 32'(e.tgt));
        check("sb_status", 32'(status), 32'(e.st));
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic mode, input logic [19:0] res,
                      input logic c, input logic [2:0] d);
    int n = 0;
    in_valid = 1'b1; in_op = op; in_mode = mode; in_result = res; in_carry = c; in_dest = d;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      check("send_timeout", 32'(in_ready), 32'd1);
    end else begin
      @(posedge clk);
      model(op, mode, res, c, d);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk); n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    m_st = 4'b0000;
    m_trapped = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = NOP; in_mode = 1'b0; in_result = '0;
    in_carry = 1'b0; in_dest = '0; wb_ready = 1'b1; trap_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_wb_we", 32'(wb_we), 32'd0);
    check("rst_br_taken", 32'(br_taken), 32'd0);
    check("rst_status", 32'(status), 32'd0);
    check("rst_trapped", 32'(trapped), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_wb_data", 32'(wb_data), 32'd0);

    // Full-word write, two-cycle latency from an empty FIFO.
    send(WRF, 1'b1, 20'h80000, 1'b0, 3'd3);
    @(negedge clk);
    check("lat_head_cycle", 32'(wb_we), 32'd0);
    @(negedge clk);
    check("lat_wb_we", 32'(wb_we), 32'd1);
    check("lat_wb_addr", 32'(wb_addr), 32'd3);
    check("lat_wb_data", 32'(wb_data), 32'h80000);
    check("lat_status", 32'(status), 32'b0010);

    // Half-word masking to zero, then JZ sees the fresh Z flag.
    send(WRF, 1'b0, 20'hFFC00, 1'b0, 3'd1);
    send(JZ, 1'b1, 20'h00123, 1'b0, 3'd0);
    drain();
    check("jz_status", 32'(status), 32'b0001);
    check("jz_target", 32'(br_target), 32'h00123);

    // LSR/XSR on the low flags; T stays untouched; then conditional jumps.
    send(LSR, 1'b1, 20'h0000F, 1'b0, 3'd0);
    drain();
    check("lsr_status", 32'(status), 32'b0111);
    send(LSR, 1'b1, 20'h00009, 1'b0, 3'd0);
    drain();
    check("lsr_no_t", 32'(status), 32'b0001);
    send(XSR, 1'b1, 20'h00003, 1'b0, 3'd0);
    send(JS, 1'b1, 20'h00456, 1'b0, 3'd0);
    send(JZ, 1'b1, 20'h00789, 1'b0, 3'd0);
    send(JZS, 1'b1, 20'hABCDE, 1'b0, 3'd0);
    send(4'hC, 1'b1, 20'h12345, 1'b1, 3'd7);
    send(NOP, 1'b1, 20'h54321, 1'b1, 3'd7);
    drain();
    check("xsr_status", 32'(status), 32'b0010);
    check("jzs_target", 32'(br_target), 32'hABCDE);

    // Half-word sign from bit 9, carry capture, WRN keeps flags.
    send(WRF, 1'b0, 20'h7F200, 1'b1, 3'd2);
    send(WRN, 1'b1, 20'h00000, 1'b0, 3'd4);
    send(JMP, 1'b0, 20'hFF3FF, 1'b0, 3'd0);
    drain();
    check("half_sign_status", 32'(status), 32'b0110);
    check("jmp_half_target", 32'(br_target), 32'h003FF);

    // Back-pressure: two accepted, third waits, then consecutive retires.
    wb_ready = 1'b0;
    send(WRN, 1'b1, 20'h11111, 1'b0, 3'd1);
    send(WRN, 1'b1, 20'h22222, 1'b0, 3'd2);
    check("full_in_ready", 32'(in_ready), 32'd0);
    wb_ready = 1'b1;
    fork
      send(WRN, 1'b1, 20'h33333, 1'b0, 3'd3);
      begin
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("consec_we", 32'(wb_we), 32'd1);
        end
      end
    join
    drain();

    // trap_clr while running is ignored.
    trap_clr = 1'b1;
    @(posedge clk); #1;
    trap_clr = 1'b0;
    check("clr_in_run_trapped", 32'(trapped), 32'd0);
    check("clr_in_run_status", 32'(status), 32'b0110);

    // TRAP discards the WRF queued behind it.
    wb_ready = 1'b0;
    send(TRAP, 1'b1, 20'h00000, 1'b0, 3'd0);
    send(WRF, 1'b1, 20'h55555, 1'b0, 3'd5);
    check("trap_full_ready", 32'(in_ready), 32'd0);
    wb_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("trap_trapped", 32'(trapped), 32'd1);
    check("trap_status", 32'(status), 32'b1110);
    repeat (4) @(negedge clk);
    check("trap_in_ready", 32'(in_ready), 32'd0);
    check("trap_no_write", 32'(wb_data), 32'h33333);
    trap_clr = 1'b1;
    @(posedge clk); #1;
    trap_clr = 1'b0;
    m_trapped = 1'b0;
    m_st[3] = 1'b0;
    check("clr_trapped", 32'(trapped), 32'd0);
    check("clr_status", 32'(status), 32'b0110);
    check("clr_in_ready", 32'(in_ready), 32'd1);
    send(WRF, 1'b1, 20'h00001, 1'b0, 3'd6);
    drain();

    // Reset with two buffered entries.
    wb_ready = 1'b0;
    send(WRF, 1'b1, 20'h66666, 1'b1, 3'd1);
    send(JMP, 1'b1, 20'h77777, 1'b0, 3'd0);
    check("prerst_in_ready", 32'(in_ready), 32'd0);
    pulse_reset();
    check("midrst_wb_we", 32'(wb_we), 32'd0);
    check("midrst_wb_addr", 32'(wb_addr), 32'd0);
    check("midrst_wb_data", 32'(wb_data), 32'd0);
    check("midrst_br_target", 32'(br_target), 32'd0);
    check("midrst_status", 32'(status), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    wb_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("midrst_discard", 32'(wb_data), 32'd0);

    // Reset while trapped.
    send(TRAP, 1'b1, 20'h00000, 1'b0, 3'd0);
    repeat (3) @(negedge clk);
    check("pretrap_rst_trapped", 32'(trapped), 32'd1);
    @(posedge clk); #1;
    pulse_reset();
    check("traprst_trapped", 32'(trapped), 32'd0);
    check("traprst_status", 32'(status), 32'd0);
    check("traprst_in_ready", 32'(in_ready), 32'd1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
